// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register dump reader.
package reg_dump_pkg;

    localparam int unsigned REG_DUMP_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready beat stream carrying one dumped register per beat.
interface reg_dump_reader_if
    import reg_dump_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DUMP_DATA_W,
    parameter int unsigned IDX_W  = 3
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/reg_snapshot.sv
// Register bank snapshot: whole bank captured on one shared load enable.
module reg_snapshot
    import reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_W   = REG_DUMP_DATA_W
) (
    input  logic                         clk,
    input  logic                         clear_n,
    input  logic                         load,
    input  logic [NUM_REGS*DATA_W-1:0]   d,
    output logic [NUM_REGS*DATA_W-1:0]   q
);

    // Capture the full bank in a single cycle; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Snapshots the live register bank on start and streams it out one
// register per beat. Optional macro REG_DUMP_CHECKSUM_EN appends a
// checksum beat (out_idx = NUM_REGS, data = byte sum of the snapshot).
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_W   = REG_DUMP_DATA_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    input  logic                       start,
    input  logic                       abort,
    reg_dump_reader_if.master          dump,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS + 1);
    localparam int unsigned SEL_W = $clog2(NUM_REGS);
    localparam int unsigned NSEL  = 1 << SEL_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        load;
    logic                        accept;
    logic [NUM_REGS*DATA_W-1:0]  snap;
    logic [DATA_W-1:0]           snap_arr [NSEL];
    logic [DATA_W-1:0]           live_arr [NSEL];
    logic [SEL_W-1:0]            sel;

    logic                        valid_d;
    logic [DATA_W-1:0]           data_d;
    logic [IDX_W-1:0]            oidx_d;
    logic                        busy_d;
    logic                        done_d;

    reg_snapshot #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_snap (
        .clk     (clk),
        .clear_n (rstn),
        .load    (load),
        .d       (reg_in),
        .q       (snap)
    );

    for (genvar g = 0; g < NSEL; g++) begin : g_unpack
        if (g < NUM_REGS) begin : g_real
            assign snap_arr[g] = snap[g*DATA_W +: DATA_W];
            assign live_arr[g] = reg_in[g*DATA_W +: DATA_W];
        end else begin : g_pad
            assign snap_arr[g] = '0;
            assign live_arr[g] = '0;
        end
    end

    assign accept = dump.out_valid && dump.out_ready;
    assign sel    = idx_d[SEL_W-1:0];

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Running byte sum of accepted register beats.
    always_comb begin
        csum_d = csum_q;
        if (load) begin
            csum_d = '0;
        end else if (state_q == SEND && accept) begin
            csum_d = csum_q + dump.out_data;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // State and beat index registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and index logic; abort wins over accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = CSUM;
                        idx_d   = IDX_W'(NUM_REGS);
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the next cycle; the snapshot is not yet loaded on
    // the start edge, so the first beat is taken straight from reg_in.
    always_comb begin
        valid_d = 1'b0;
        data_d  = '0;
        oidx_d  = '0;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        case (state_d)
            SEND: begin
                valid_d = 1'b1;
                oidx_d  = idx_d;
                data_d  = load ? live_arr[sel] : snap_arr[sel];
            end
            CSUM: begin
                valid_d = 1'b1;
                oidx_d  = idx_d;
`ifdef REG_DUMP_CHECKSUM_EN
                data_d  = csum_d;
`endif
            end
            default: begin
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dump.out_valid <= 1'b0;
            dump.out_data  <= '0;
            dump.out_idx   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            dump.out_valid <= valid_d;
            dump.out_data  <= data_d;
            dump.out_idx   <= oidx_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

endmodule
